ram_even_bank: RTL and testbench



---
 rtl/ram_even_bank.sv | 140 ++++++++++++++
 tb/tb_ram_even_bank.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_even_bank.sv
// ram_even_bank: sample storage for the JPEG-2000 5/3 lifting datapath.
//
// Three independent DATA_W x 2**ADDR_W memories, each with a synchronous
// write and a registered (one-cycle) read:
//   L    - line buffer with two write ports (L and R channels), read on L
//   EVEN - even-indexed samples
//   ODD  - odd-indexed samples
//
// Default build: read-during-write to the same address returns the OLD word.
// Define RAM_EVEN_BANK_WRITE_FIRST_EN to bypass the write data onto the read
// path instead, so a same-address read returns the NEW word.
//
// Memory contents are never cleared by reset; only the read registers are.

module ram_even_bank #(
    parameter int DATA_W = 26,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [ADDR_W-1:0] pix_addr_l,
    input  logic [DATA_W-1:0] pix_din_l,
    input  logic              pix_we_l,
    output logic [DATA_W-1:0] pix_dout_l,

    input  logic [ADDR_W-1:0] pix_addr_r,
    input  logic [DATA_W-1:0] pix_din_r,
    input  logic              pix_we_r,
    input  logic [DATA_W-1:0] pix_dout_r,

    input  logic [ADDR_W-1:0] pix_addr_even,
    input  logic [DATA_W-1:0] pix_din_even,
    input  logic              pix_we_even,
    output logic [DATA_W-1:0] pix_dout_even,

    input  logic [ADDR_W-1:0] pix_addr_odd,
    input  logic [DATA_W-1:0] pix_din_odd,
    input  logic              pix_we_odd,
    output logic [DATA_W-1:0] pix_dout_odd
);

    localparam int DEPTH = 1 << ADDR_W;

    // Storage arrays; deliberately without reset so they can map onto RAM.
    logic [DATA_W-1:0] memL    [DEPTH];
    logic [DATA_W-1:0] memEven [DEPTH];
    logic [DATA_W-1:0] memOdd  [DEPTH];

    // Registered read data and the value each register loads next.
    logic [DATA_W-1:0] doutL_q,    doutL_d;
    logic [DATA_W-1:0] doutEven_q, doutEven_d;
    logic [DATA_W-1:0] doutOdd_q,  doutOdd_d;

    // Write strobes qualified by reset: no write lands while rst_n is low.
    logic wrL, wrR, wrEven, wrOdd;

    // The right-neighbour input exists only for interface compatibility.
    logic unusedDoutR;

    assign unusedDoutR = ^pix_dout_r;

    assign wrL    = pix_we_l    & rst_n;
    assign wrR    = pix_we_r    & rst_n;
    assign wrEven = pix_we_even & rst_n;
    assign wrOdd  = pix_we_odd  & rst_n;

    // Memory L write: R first, then L, so an L write to the same address wins.
    always_ff @(posedge clk) begin
        if (wrR) begin
            memL[pix_addr_r] <= pix_din_r;
        end
        if (wrL) begin
            memL[pix_addr_l] <= pix_din_l;
        end
    end

    // Memory EVEN write port.
    always_ff @(posedge clk) begin
        if (wrEven) begin
            memEven[pix_addr_even] <= pix_din_even;
        end
    end

    // Memory ODD write port.
    always_ff @(posedge clk) begin
        if (wrOdd) begin
            memOdd[pix_addr_odd] <= pix_din_odd;
        end
    end

`ifdef RAM_EVEN_BANK_WRITE_FIRST_EN
    // Write-first read path: same-address writes bypass onto the read data,
    // with the L port taking priority over the R port on memory L.
    always_comb begin
        doutL_d    = memL[pix_addr_l];
        doutEven_d = memEven[pix_addr_even];
        doutOdd_d  = memOdd[pix_addr_odd];

        if (pix_we_l) begin
            doutL_d = pix_din_l;
        end else if (pix_we_r && (pix_addr_r == pix_addr_l)) begin
            doutL_d = pix_din_r;
        end

        if (pix_we_even) begin
            doutEven_d = pix_din_even;
        end

        if (pix_we_odd) begin
            doutOdd_d = pix_din_odd;
        end
    end
`else
    // Read-first read path: always sample the array as it stood before this edge.
    always_comb begin
        doutL_d    = memL[pix_addr_l];
        doutEven_d = memEven[pix_addr_even];
        doutOdd_d  = memOdd[pix_addr_odd];
    end
`endif

    // Read registers: cleared asynchronously, reloaded on every active edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            doutL_q    <= '0;
            doutEven_q <= '0;
            doutOdd_q  <= '0;
        end else begin
            doutL_q    <= doutL_d;
            doutEven_q <= doutEven_d;
            doutOdd_q  <= doutOdd_d;
        end
    end

    assign pix_dout_l    = doutL_q;
    assign pix_dout_even = doutEven_q;
    assign pix_dout_odd  = doutOdd_q;

endmodule

// File: tb/tb_ram_even_bank.sv
// tb_ram_even_bank: directed self-checking bench for ram_even_bank.
// Honours RAM_EVEN_BANK_WRITE_FIRST_EN for the read-during-write expectations.

module tb_ram_even_bank;

    logic        clk;
    logic        rst_n;
    logic [6:0]  pix_addr_l;
    logic [25:0] pix_din_l;
    logic        pix_we_l;
    logic [25:0] pix_dout_l;
    logic [6:0]  pix_addr_r;
    logic [25:0] pix_din_r;
    logic        pix_we_r;
    logic [25:0] pix_dout_r;
    logic [6:0]  pix_addr_even;
    logic [25:0] pix_din_even;
    logic        pix_we_even;
    logic [25:0] pix_dout_even;
    logic [6:0]  pix_addr_odd;
    logic [25:0] pix_din_odd;
    logic        pix_we_odd;
    logic [25:0] pix_dout_odd;

    int testCount;
    int failCount;

    ram_even_bank dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pix_addr_l    (pix_addr_l),
        .pix_din_l     (pix_din_l),
        .pix_we_l      (pix_we_l),
        .pix_dout_l    (pix_dout_l),
        .pix_addr_r    (pix_addr_r),
        .pix_din_r     (pix_din_r),
        .pix_we_r      (pix_we_r),
        .pix_dout_r    (pix_dout_r),
        .pix_addr_even (pix_addr_even),
        .pix_din_even  (pix_din_even),
        .pix_we_even   (pix_we_even),
        .pix_dout_even (pix_dout_even),
        .pix_addr_odd  (pix_addr_odd),
        .pix_din_odd   (pix_din_odd),
        .pix_we_odd    (pix_we_odd),
        .pix_dout_odd  (pix_dout_odd)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Per-address sweep patterns: each embeds the address so aliasing shows.
    function automatic logic [25:0] patL(input logic [6:0] a);
        return {a, 12'h5A5, ~a};
    endfunction

    function automatic logic [25:0] patE(input logic [6:0] a);
        return {a, 12'hABC, a};
    endfunction

    function automatic logic [25:0] patO(input logic [6:0] a);
        return {~a, 12'h123, a};
    endfunction

    task automatic clearWrites();
        pix_we_l    = 1'b0;
        pix_we_r    = 1'b0;
        pix_we_even = 1'b0;
        pix_we_odd  = 1'b0;
    endtask

    // Advance to just after the next rising edge; inputs change only here.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        pix_dout_r = 26'($urandom);
    endtask

    task automatic checkOutput(input string tag, input logic [25:0] observed,
                               input logic [25:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%07h expected 0x%07h", tag, observed, expected);
        end
    endtask

    initial begin
        testCount     = 0;
        failCount     = 0;
        rst_n         = 1'b0;
        pix_addr_l    = '0;
        pix_din_l     = '0;
        pix_addr_r    = '0;
        pix_din_r     = '0;
        pix_dout_r    = '0;
        pix_addr_even = '0;
        pix_din_even  = '0;
        pix_addr_odd  = '0;
        pix_din_odd   = '0;
        clearWrites();

        // Power-on reset: read registers held at zero.
        applyStimulus();
        applyStimulus();
        checkOutput("reset_l",    pix_dout_l,    26'h0);
        checkOutput("reset_even", pix_dout_even, 26'h0);
        checkOutput("reset_odd",  pix_dout_odd,  26'h0);
        rst_n = 1'b1;

        // Write EVEN[5], read it back one edge later.
        pix_addr_even = 7'd5;
        pix_din_even  = 26'h155AAAA;
        pix_we_even   = 1'b1;
        applyStimulus();
        clearWrites();
        applyStimulus();
        checkOutput("even5_before_reset", pix_dout_even, 26'h155AAAA);

        // Mid-operation reset clears outputs asynchronously, before any edge.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_l",    pix_dout_l,    26'h0);
        checkOutput("async_reset_even", pix_dout_even, 26'h0);
        checkOutput("async_reset_odd",  pix_dout_odd,  26'h0);

        // Write attempted during reset must be suppressed.
        pix_din_even = 26'h0001234;
        pix_we_even  = 1'b1;
        applyStimulus();
        checkOutput("reset_holds_even", pix_dout_even, 26'h0);
        clearWrites();
        rst_n = 1'b1;
        applyStimulus();
        checkOutput("even5_kept_across_reset", pix_dout_even, 26'h155AAAA);

        // Basic write/read on each memory.
        pix_addr_even = 7'd0;
        pix_din_even  = 26'h0000001;
        pix_we_even   = 1'b1;
        pix_addr_odd  = 7'd127;
        pix_din_odd   = 26'h3FFFFFF;
        pix_we_odd    = 1'b1;
        pix_addr_l    = 7'd64;
        pix_din_l     = 26'h2000000;
        pix_we_l      = 1'b1;
        applyStimulus();
        clearWrites();
        applyStimulus();
        checkOutput("even0",  pix_dout_even, 26'h0000001);
        checkOutput("odd127", pix_dout_odd,  26'h3FFFFFF);
        checkOutput("l64",    pix_dout_l,    26'h2000000);

        // Latency: a new address shows nothing until the next edge.
        pix_addr_even = 7'd5;
        #1;
        checkOutput("even_hold_no_edge", pix_dout_even, 26'h0000001);
        applyStimulus();
        checkOutput("even_after_edge", pix_dout_even, 26'h155AAAA);

        // Read-during-write on L: write L[3]=7, then overwrite with 9.
        pix_addr_l = 7'd3;
        pix_din_l  = 26'd7;
        pix_we_l   = 1'b1;
        applyStimulus();
        pix_din_l  = 26'd9;
        applyStimulus();
`ifdef RAM_EVEN_BANK_WRITE_FIRST_EN
        checkOutput("rdw_l_first_edge", pix_dout_l, 26'd9);
`else
        checkOutput("rdw_l_first_edge", pix_dout_l, 26'd7);
`endif
        clearWrites();
        applyStimulus();
        checkOutput("rdw_l_next_edge", pix_dout_l, 26'd9);

        // Read-during-write on EVEN[0] (holds 1).
        pix_addr_even = 7'd0;
        pix_din_even  = 26'd2;
        pix_we_even   = 1'b1;
        applyStimulus();
`ifdef RAM_EVEN_BANK_WRITE_FIRST_EN
        checkOutput("rdw_even", pix_dout_even, 26'd2);
`else
        checkOutput("rdw_even", pix_dout_even, 26'd1);
`endif
        clearWrites();
        applyStimulus();
        checkOutput("rdw_even_next", pix_dout_even, 26'd2);

        // Dual write to L at different addresses.
        pix_addr_l = 7'd10;
        pix_din_l  = 26'h11;
        pix_we_l   = 1'b1;
        pix_addr_r = 7'd20;
        pix_din_r  = 26'h22;
        pix_we_r   = 1'b1;
        applyStimulus();
        clearWrites();
        applyStimulus();
        checkOutput("dual_l10", pix_dout_l, 26'h11);
        pix_addr_l = 7'd20;
        applyStimulus();
        checkOutput("dual_l20", pix_dout_l, 26'h22);

        // Same-address collision: L write wins.
        pix_addr_l = 7'd30;
        pix_din_l  = 26'hA;
        pix_we_l   = 1'b1;
        pix_addr_r = 7'd30;
        pix_din_r  = 26'hB;
        pix_we_r   = 1'b1;
        applyStimulus();
        clearWrites();
        applyStimulus();
        checkOutput("collide_l30", pix_dout_l, 26'hA);

        // Collision while L reads the same address (L[30]=0xA beforehand).
        pix_din_l = 26'hC;
        pix_we_l  = 1'b1;
        pix_din_r = 26'hD;
        pix_we_r  = 1'b1;
        applyStimulus();
`ifdef RAM_EVEN_BANK_WRITE_FIRST_EN
        checkOutput("collide_rdw", pix_dout_l, 26'hC);
`else
        checkOutput("collide_rdw", pix_dout_l, 26'hA);
`endif
        clearWrites();
        applyStimulus();
        checkOutput("collide_rdw_next", pix_dout_l, 26'hC);

        // R writes the address L is reading (L[20]=0x22 beforehand).
        pix_addr_l = 7'd20;
        pix_addr_r = 7'd20;
        pix_din_r  = 26'h33;
        pix_we_r   = 1'b1;
        applyStimulus();
`ifdef RAM_EVEN_BANK_WRITE_FIRST_EN
        checkOutput("r_write_l_read", pix_dout_l, 26'h33);
`else
        checkOutput("r_write_l_read", pix_dout_l, 26'h22);
`endif
        clearWrites();
        applyStimulus();
        checkOutput("r_write_l_read_next", pix_dout_l, 26'h33);

        // Independence: EVEN[9] and ODD[9] on one edge, L untouched.
        pix_addr_l    = 7'd30;
        pix_addr_even = 7'd9;
        pix_din_even  = 26'h100;
        pix_we_even   = 1'b1;
        pix_addr_odd  = 7'd9;
        pix_din_odd   = 26'h200;
        pix_we_odd    = 1'b1;
        applyStimulus();
        clearWrites();
        applyStimulus();
        checkOutput("indep_even9", pix_dout_even, 26'h100);
        checkOutput("indep_odd9",  pix_dout_odd,  26'h200);
        checkOutput("indep_l30",   pix_dout_l,    26'hC);

        // Sweep: fill every address (L alternately via L and R ports).
        for (int a = 0; a < 128; a++) begin
            pix_addr_l    = 7'(a);
            pix_addr_r    = 7'(a);
            pix_din_l     = patL(7'(a));
            pix_din_r     = patL(7'(a));
            pix_we_l      = ((a % 2) == 0);
            pix_we_r      = ((a % 2) == 1);
            pix_addr_even = 7'(a);
            pix_din_even  = patE(7'(a));
            pix_we_even   = 1'b1;
            pix_addr_odd  = 7'(a);
            pix_din_odd   = patO(7'(a));
            pix_we_odd    = 1'b1;
            applyStimulus();
        end
        clearWrites();

        // Sweep readback, descending so wrap from 127 down is exercised too.
        for (int a = 127; a >= 0; a--) begin
            pix_addr_l    = 7'(a);
            pix_addr_even = 7'(a);
            pix_addr_odd  = 7'(a);
            applyStimulus();
            checkOutput($sformatf("sweep_l[%0d]", a),    pix_dout_l,    patL(7'(a)));
            checkOutput($sformatf("sweep_even[%0d]", a), pix_dout_even, patE(7'(a)));
            checkOutput($sformatf("sweep_odd[%0d]", a),  pix_dout_odd,  patO(7'(a)));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
